mx_port_bringup_ctrl: RTL and testbench

Per-port bring-up sequencer for the 1G/10G transceiver control signals.
- Synchronises and debounces the SFP status pins (mod_abs, rx_los, tx_fault, lopc).
- Sequences the PHY resets, gbe_coma, tx_disable and main_engine_arst.
- Publishes port speed and the alarm/rx LEDs.
- Its outputs drive the master modport of mx_xgbe_ctrl_if at the port top level. Settings come from the register block.

---
 rtl/mx_port_bringup_pkg.sv | 48 ++++
 rtl/mx_sig_debounce.sv | 46 ++++
 rtl/mx_port_bringup_ctrl.sv | 156 +++++++++++++++
 tb/tb_mx_port_bringup_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mx_port_bringup_pkg.sv
// Shared types and constants for the per-port transceiver bring-up sequencer.
package mx_port_bringup_pkg;

  localparam int unsigned SPEED_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_TX_ON   = 3'd3,
    ST_UP      = 3'd4,
    ST_FAULT   = 3'd5,
    ST_LOCKOUT = 3'd6
  } state_e;

  localparam logic [SPEED_W-1:0] SPEED_10G  = 4'b0000;
  localparam logic [SPEED_W-1:0] SPEED_10M  = 4'b1001;
  localparam logic [SPEED_W-1:0] SPEED_100M = 4'b1010;
  localparam logic [SPEED_W-1:0] SPEED_1G   = 4'b1100;

  typedef struct packed {
    logic tx_disable;
    logic xge_nreset;
    logic gbe_nreset;
    logic gbe_coma;
    logic main_engine_arst;
    logic link_up;
    logic rx_led;
    logic alrm_led;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_IDLE = '{
    tx_disable:       1'b1,
    xge_nreset:       1'b0,
    gbe_nreset:       1'b0,
    gbe_coma:         1'b1,
    main_engine_arst: 1'b1,
    link_up:          1'b0,
    rx_led:           1'b0,
    alrm_led:         1'b0
  };

  function automatic logic speed_valid(input logic [SPEED_W-1:0] code);
    return (code == SPEED_10G) || (code == SPEED_10M) ||
           (code == SPEED_100M) || (code == SPEED_1G);
  endfunction

endpackage

// File: rtl/mx_sig_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle stability filter.
module mx_sig_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000,
  parameter logic        RST_VAL      = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic db_o
);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles the synced pin disagrees with the filtered value; agreement restarts.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/mx_port_bringup_ctrl.sv
// Per-port bring-up sequencer: debounces SFP status pins and steps the PHY
// resets, coma, tx_disable and engine reset through a timed state machine.
module mx_port_bringup_ctrl
  import mx_port_bringup_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC    = 1000,
  parameter int unsigned RST_HOLD_CYC    = 256,
  parameter int unsigned SETTLE_CYC      = 1024,
  parameter int unsigned FAULT_RETRY_MAX = 3,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               port_en_i,
  input  logic [SPEED_W-1:0] speed_sel_i,
  input  logic               soft_restart_i,
  input  logic               mod_abs_i,
  input  logic               rx_los_i,
  input  logic               tx_fault_i,
  input  logic               lopc_i,
  output logic               tx_disable_o,
  output logic               xge_nreset_o,
  output logic               gbe_nreset_o,
  output logic               gbe_coma_o,
  output logic               main_engine_arst_o,
  output logic [SPEED_W-1:0] rx_port_speed_o,
  output logic [SPEED_W-1:0] tx_port_speed_o,
  output logic               alrm_led_o,
  output logic               rx_led_o,
  output logic               link_up_o,
  output logic               cfg_err_o,
  output logic [1:0]         fault_cnt_o,
  output logic [2:0]         state_o
);

  logic mod_abs_db, rx_los_db, tx_fault_db, lopc_db;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               cfg_err_q, cfg_err_d;
  logic [1:0]         fault_cnt_q, fault_cnt_d;
  logic               restart;
  ctrl_out_t          out_q, out_d;

  mx_sig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1), .CNT_W(CNT_W)) u_db_mod_abs (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(mod_abs_i), .db_o(mod_abs_db));
  mx_sig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1), .CNT_W(CNT_W)) u_db_rx_los (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(rx_los_i), .db_o(rx_los_db));
  mx_sig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b0), .CNT_W(CNT_W)) u_db_tx_fault (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(tx_fault_i), .db_o(tx_fault_db));
  mx_sig_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1), .CNT_W(CNT_W)) u_db_lopc (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(lopc_i), .db_o(lopc_db));

  // Next state, speed latch, config error and fault accounting.
  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    cfg_err_d   = cfg_err_q;
    fault_cnt_d = fault_cnt_q;
    restart     = 1'b0;
    if (!port_en_i || mod_abs_db) begin
      state_d = ST_IDLE;
    end else if (soft_restart_i && (state_q != ST_IDLE)) begin
      fault_cnt_d = '0;
      restart     = 1'b1;
      if (speed_valid(speed_sel_i)) begin
        speed_d   = speed_sel_i;
        cfg_err_d = 1'b0;
        state_d   = ST_RESET;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (speed_valid(speed_sel_i)) begin
            speed_d   = speed_sel_i;
            cfg_err_d = 1'b0;
            state_d   = ST_RESET;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        ST_RESET:  if (timer_q == CNT_W'(RST_HOLD_CYC - 1)) state_d = ST_SETTLE;
        ST_SETTLE: if (timer_q == CNT_W'(SETTLE_CYC - 1)) state_d = ST_TX_ON;
        ST_TX_ON: begin
          if (tx_fault_db)                 state_d = ST_FAULT;
          else if (!rx_los_db && !lopc_db) state_d = ST_UP;
        end
        ST_UP: begin
          if (tx_fault_db)                state_d = ST_FAULT;
          else if (rx_los_db || lopc_db)  state_d = ST_TX_ON;
        end
        ST_FAULT: begin
          fault_cnt_d = (fault_cnt_q == 2'd3) ? 2'd3 : fault_cnt_q + 2'd1;
          state_d     = (fault_cnt_d == 2'(FAULT_RETRY_MAX)) ? ST_LOCKOUT : ST_RESET;
        end
        ST_LOCKOUT: state_d = ST_LOCKOUT;
        default:    state_d = ST_IDLE;
      endcase
    end
    timer_d = ((state_d != state_q) || restart) ? '0 : timer_q + CNT_W'(1);
  end

  // Output image of the state being entered, so outputs line up with state_o.
  always_comb begin
    out_d = CTRL_IDLE;
    if (state_d inside {ST_SETTLE, ST_TX_ON, ST_UP, ST_FAULT}) begin
      out_d.xge_nreset = (speed_d == SPEED_10G);
      out_d.gbe_nreset = (speed_d != SPEED_10G);
      out_d.gbe_coma   = (speed_d == SPEED_10G);
    end
    if (state_d inside {ST_TX_ON, ST_UP}) begin
      out_d.tx_disable       = 1'b0;
      out_d.main_engine_arst = 1'b0;
    end
    out_d.link_up  = (state_d == ST_UP);
    out_d.rx_led   = (state_d == ST_UP);
    out_d.alrm_led = (state_d == ST_LOCKOUT) || (port_en_i && mod_abs_db) || cfg_err_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      speed_q     <= SPEED_10G;
      cfg_err_q   <= 1'b0;
      fault_cnt_q <= '0;
      out_q       <= CTRL_IDLE;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      speed_q     <= speed_d;
      cfg_err_q   <= cfg_err_d;
      fault_cnt_q <= fault_cnt_d;
      out_q       <= out_d;
    end
  end

  assign tx_disable_o       = out_q.tx_disable;
  assign xge_nreset_o       = out_q.xge_nreset;
  assign gbe_nreset_o       = out_q.gbe_nreset;
  assign gbe_coma_o         = out_q.gbe_coma;
  assign main_engine_arst_o = out_q.main_engine_arst;
  assign link_up_o          = out_q.link_up;
  assign rx_led_o           = out_q.rx_led;
  assign alrm_led_o         = out_q.alrm_led;
  assign rx_port_speed_o    = speed_q;
  assign tx_port_speed_o    = speed_q;
  assign cfg_err_o          = cfg_err_q;
  assign fault_cnt_o        = fault_cnt_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_mx_port_bringup_ctrl.sv
// Bench for mx_port_bringup_ctrl: behavioural model compared every cycle plus
// directed bring-up, glitch, fault, lockout, config-error and reset scenarios.
module tb_mx_port_bringup_ctrl;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int SETL  = 16;
  localparam int RETRY = 2;

  localparam int S_IDLE = 0, S_RESET = 1, S_SETTLE = 2, S_TX_ON = 3,
                 S_UP = 4, S_FAULT = 5, S_LOCKOUT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       port_en = 1'b0;
  logic [3:0] speed_sel = 4'b0000;
  logic       soft_restart = 1'b0;
  logic       mod_abs = 1'b1, rx_los = 1'b1, tx_fault = 1'b0, lopc = 1'b1;

  logic       tx_disable, xge_nreset, gbe_nreset, gbe_coma, main_engine_arst;
  logic [3:0] rx_port_speed, tx_port_speed;
  logic       alrm_led, rx_led, link_up, cfg_err;
  logic [1:0] fault_cnt;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  mx_port_bringup_ctrl #(
    .DEBOUNCE_CYC(DEB), .RST_HOLD_CYC(HOLD), .SETTLE_CYC(SETL),
    .FAULT_RETRY_MAX(RETRY), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .port_en_i(port_en), .speed_sel_i(speed_sel),
    .soft_restart_i(soft_restart), .mod_abs_i(mod_abs), .rx_los_i(rx_los),
    .tx_fault_i(tx_fault), .lopc_i(lopc), .tx_disable_o(tx_disable),
    .xge_nreset_o(xge_nreset), .gbe_nreset_o(gbe_nreset), .gbe_coma_o(gbe_coma),
    .main_engine_arst_o(main_engine_arst), .rx_port_speed_o(rx_port_speed),
    .tx_port_speed_o(tx_port_speed), .alrm_led_o(alrm_led), .rx_led_o(rx_led),
    .link_up_o(link_up), .cfg_err_o(cfg_err), .fault_cnt_o(fault_cnt), .state_o(state)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 0;
  int          m_state, m_time, m_fault;
  logic [3:0]  m_speed;
  bit          m_cfg, m_alrm;
  bit          m_db[4];
  logic [15:0] m_hist[4];
  localparam bit RV[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  function automatic bit valid_speed(input logic [3:0] s);
    return s == 4'b0000 || s == 4'b1001 || s == 4'b1010 || s == 4'b1100;
  endfunction

  // {tx_disable, xge_nreset, gbe_nreset, gbe_coma, arst, link_up, rx_led}
  function automatic logic [6:0] exp_ctrl(input int st, input logic [3:0] spd);
    bit released, traffic, is10g;
    released = (st == S_SETTLE) || (st == S_TX_ON) || (st == S_UP) || (st == S_FAULT);
    traffic  = (st == S_TX_ON) || (st == S_UP);
    is10g    = (spd == 4'b0000);
    return {!traffic, released && is10g, released && !is10g,
            !(released && !is10g), !traffic, st == S_UP, st == S_UP};
  endfunction

  task automatic model_step();
    bit db_old[4];
    bit pins[4];
    bit restarted, all_differ;
    int ns;
    if (rst) begin
      m_state = S_IDLE; m_time = 1; m_fault = 0; m_speed = 4'b0000;
      m_cfg = 0; m_alrm = 0; m_valid = 1;
      for (int i = 0; i < 4; i++) begin
        m_db[i] = RV[i];
        m_hist[i] = {16{RV[i]}};
      end
      return;
    end
    if (!m_valid) return;
    db_old = m_db;
    pins = '{mod_abs, rx_los, tx_fault, lopc};
    restarted = 0;
    ns = m_state;
    if (!port_en || db_old[0]) ns = S_IDLE;
    else if (soft_restart && m_state != S_IDLE) begin
      m_fault = 0; restarted = 1;
      if (valid_speed(speed_sel)) begin m_speed = speed_sel; m_cfg = 0; ns = S_RESET; end
      else begin m_cfg = 1; ns = S_IDLE; end
    end else if (m_state == S_IDLE) begin
      if (valid_speed(speed_sel)) begin m_speed = speed_sel; m_cfg = 0; ns = S_RESET; end
      else m_cfg = 1;
    end else if (m_state == S_RESET && m_time == HOLD) ns = S_SETTLE;
    else if (m_state == S_SETTLE && m_time == SETL) ns = S_TX_ON;
    else if ((m_state == S_TX_ON || m_state == S_UP) && db_old[2]) ns = S_FAULT;
    else if (m_state == S_TX_ON && !db_old[1] && !db_old[3]) ns = S_UP;
    else if (m_state == S_UP && (db_old[1] || db_old[3])) ns = S_TX_ON;
    else if (m_state == S_FAULT) begin
      m_fault = (m_fault < 3) ? m_fault + 1 : 3;
      ns = (m_fault == RETRY) ? S_LOCKOUT : S_RESET;
    end
    m_alrm = (ns == S_LOCKOUT) || (port_en && db_old[0]) || m_cfg;
    m_time = (ns != m_state || restarted) ? 1 : m_time + 1;
    m_state = ns;
    // Filtered value flips once the pin seen through two sync stages disagreed DEB times in a row.
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = {m_hist[i][14:0], pins[i]};
      all_differ = 1;
      for (int j = 2; j < DEB + 2; j++) if (m_hist[i][j] == m_db[i]) all_differ = 0;
      if (all_differ) m_db[i] = !m_db[i];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", 32'(state), 32'(m_state));
      chk("ctrl", 32'({tx_disable, xge_nreset, gbe_nreset, gbe_coma, main_engine_arst, link_up, rx_led}),
          32'(exp_ctrl(m_state, m_speed)));
      chk("port_speed", 32'({rx_port_speed, tx_port_speed}), 32'({m_speed, m_speed}));
      chk("fault_cnt", 32'(fault_cnt), 32'(m_fault));
      chk("cfg_err", 32'(cfg_err), 32'(m_cfg));
      chk("alrm_led", 32'(alrm_led), 32'(m_alrm));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_state(input int tgt, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (32'(state) != 32'(tgt) && n < budget);
    if (32'(state) != 32'(tgt)) begin
      checks++;
      failures++;
      $display("FAIL wait_state: timeout waiting for %0d, got %0d", tgt, state);
    end
  endtask

  task automatic pulse_restart();
    soft_restart = 1'b1;
    @(negedge clk);
    soft_restart = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_ctrl", 32'({tx_disable, xge_nreset, gbe_nreset, gbe_coma, main_engine_arst}), 32'b10011);
    chk("rst_speed", 32'(rx_port_speed), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: 10G bring-up
    port_en = 1'b1; mod_abs = 1'b0;
    wait_state(S_RESET, 20, n);   chk("t1_reset_lat", n, 7);
    wait_state(S_SETTLE, 20, n);  chk("t1_reset_len", n, 8);
    chk("t1_settle_phy", 32'({xge_nreset, gbe_nreset, tx_disable}), 32'b101);
    wait_state(S_TX_ON, 40, n);   chk("t1_settle_len", n, 16);
    chk("t1_txon_txdis", 32'(tx_disable), 0);
    rx_los = 1'b0; lopc = 1'b0;
    wait_state(S_UP, 20, n);      chk("t1_up_lat", n, 7);
    chk("t1_up_leds", 32'({link_up, rx_led, tx_port_speed}), 32'b11_0000);

    // 2: 1G via soft restart
    speed_sel = 4'b1100;
    pulse_restart();
    chk("t2_reset", 32'({state, rx_port_speed}), 32'({3'd1, 4'b1100}));
    wait_state(S_SETTLE, 20, n);  chk("t2_reset_len", n, 8);
    chk("t2_settle_phy", 32'({xge_nreset, gbe_nreset, gbe_coma}), 32'b010);
    wait_state(S_UP, 40, n);      chk("t2_up_lat", n, 17);
    chk("t2_speed", 32'(tx_port_speed), 32'(4'b1100));

    // 3: rx_los glitch rejection then real loss
    rx_los = 1'b1;
    repeat (3) @(negedge clk);
    rx_los = 1'b0;
    repeat (12) @(negedge clk);
    chk("t3_glitch_up", 32'(state), S_UP);
    rx_los = 1'b1;
    wait_state(S_TX_ON, 20, n);   chk("t3_loss_lat", n, 7);
    repeat (3) @(negedge clk);
    rx_los = 1'b0;
    wait_state(S_UP, 20, n);      chk("t3_recover_lat", n, 7);
    chk("t3_phy_held", 32'(gbe_nreset), 1);

    // 4: repeated tx_fault to lockout, then soft restart
    tx_fault = 1'b1;
    wait_state(S_FAULT, 20, n);   chk("t4_fault_lat", n, 7);
    @(negedge clk);
    chk("t4_retry", 32'({state, fault_cnt}), 32'({3'd1, 2'd1}));
    wait_state(S_LOCKOUT, 60, n);
    chk("t4_lockout", 32'({fault_cnt, alrm_led, tx_disable}), 32'b1011);
    tx_fault = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_lock_hold", 32'(state), S_LOCKOUT);
    pulse_restart();
    chk("t4_restart", 32'({state, fault_cnt}), 32'({3'd1, 2'd0}));
    wait_state(S_UP, 60, n);

    // 5: module pulled mid-SETTLE, then invalid speed code
    speed_sel = 4'b0000;
    pulse_restart();
    wait_state(S_SETTLE, 20, n);
    repeat (5) @(negedge clk);
    mod_abs = 1'b1;
    wait_state(S_IDLE, 20, n);    chk("t5_idle_lat", n, 7);
    chk("t5_idle_out", 32'({xge_nreset, gbe_nreset, tx_disable, alrm_led}), 32'b0011);
    speed_sel = 4'b0111; mod_abs = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_cfg_err", 32'({state, cfg_err, alrm_led}), 32'({3'd0, 2'b11}));
    speed_sel = 4'b1010;
    wait_state(S_RESET, 5, n);    chk("t5_recover", 32'({n[2:0], cfg_err}), 32'({3'd1, 1'b0}));
    wait_state(S_UP, 60, n);
    chk("t5_speed", 32'(rx_port_speed), 32'(4'b1010));

    // 6: synchronous reset while UP with a fault on record
    tx_fault = 1'b1;
    wait_state(S_FAULT, 20, n);
    tx_fault = 1'b0;
    @(negedge clk);
    chk("t6_fault1", 32'(fault_cnt), 1);
    wait_state(S_UP, 60, n);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst", 32'({state, fault_cnt, rx_port_speed, tx_disable, xge_nreset, gbe_nreset, link_up}),
        32'({3'd0, 2'd0, 4'd0, 4'b1000}));
    rst = 1'b0;
    wait_state(S_RESET, 20, n);   chk("t6_rebring_lat", n, 7);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
